// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the Data/Instruction bus arbiter: channel state
// encoding and the default core count.
package arbiter_pkg;

  localparam int DEFAULT_N_CORES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } chanState_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the cores' arbitration submodules and the
// central arbiter; master = arbiter side, slave = requester side.
interface bus_arbiter_if
  import arbiter_pkg::*;
#(
  parameter int N_CORES = DEFAULT_N_CORES,
  parameter int OWNER_W = $clog2(N_CORES)
);
  logic [N_CORES-1:0] D_Bus_RQ;
  logic [N_CORES-1:0] D_Bus_GRANT;
  logic [OWNER_W-1:0] D_Bus_Owner;
  logic               D_Bus_Busy;
  logic [N_CORES-1:0] I_Bus_RQ;
  logic [N_CORES-1:0] I_Bus_GRANT;
  logic [OWNER_W-1:0] I_Bus_Owner;
  logic               I_Bus_Busy;

  modport master (
    input  D_Bus_RQ, I_Bus_RQ,
    output D_Bus_GRANT, D_Bus_Owner, D_Bus_Busy,
    output I_Bus_GRANT, I_Bus_Owner, I_Bus_Busy
  );

  modport slave (
    output D_Bus_RQ, I_Bus_RQ,
    input  D_Bus_GRANT, D_Bus_Owner, D_Bus_Busy,
    input  I_Bus_GRANT, I_Bus_Owner, I_Bus_Busy
  );
endinterface

// File: rtl/bus_arbiter_rr_bus_channel.sv
// One round-robin bus channel: registered one-hot grant held while the owner
// requests, followed by a single dead cycle on every ownership change.
module rr_bus_channel
  import arbiter_pkg::*;
#(
  parameter int N_CORES = DEFAULT_N_CORES,
  parameter int OWNER_W = $clog2(N_CORES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_CORES-1:0] rq,
  output logic [N_CORES-1:0] grant,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  chanState_t         state, nextState;
  logic [OWNER_W-1:0] ptrQ, nextPtr;
  logic [OWNER_W-1:0] ownerQ, nextOwner;
  logic [N_CORES-1:0] grantQ, nextGrant;
  logic               pickHit;
  logic [OWNER_W-1:0] pickIdx;

  // Rotate the request vector so ptr lands at bit 0, then take the lowest
  // set bit; result is {hit, index}.
  function automatic logic [OWNER_W:0] rrPick(
    input logic [N_CORES-1:0] req,
    input logic [OWNER_W-1:0] base
  );
    logic [2*N_CORES-1:0] dbl;
    logic [N_CORES-1:0]   rot;
    int                   sum;
    rrPick = '0;
    dbl    = {req, req} >> base;
    rot    = dbl[N_CORES-1:0];
    for (int j = N_CORES - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(base) + j;
        if (sum >= N_CORES) sum = sum - N_CORES;
        rrPick = {1'b1, OWNER_W'(sum)};
      end
    end
  endfunction

  assign {pickHit, pickIdx} = rrPick(rq, ptrQ);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ptrQ   <= '0;
      ownerQ <= '0;
      grantQ <= '0;
    end else begin
      state  <= nextState;
      ptrQ   <= nextPtr;
      ownerQ <= nextOwner;
      grantQ <= nextGrant;
    end
  end

  always_comb begin
    nextState = state;
    nextPtr   = ptrQ;
    nextOwner = ownerQ;
    nextGrant = grantQ;
    case (state)
      IDLE, TURN: begin
        // TURN forces one all-zero cycle; selection then behaves as in IDLE
        nextGrant = '0;
        nextState = IDLE;
        if (pickHit) begin
          nextState = GRANT;
          nextOwner = pickIdx;
          nextGrant = N_CORES'(1) << pickIdx;
          nextPtr   = (pickIdx == OWNER_W'(N_CORES - 1)) ? '0 : pickIdx + OWNER_W'(1);
        end
      end
      GRANT: begin
        if (!rq[ownerQ]) begin
          nextGrant = '0;
          nextState = TURN;
        end
      end
      default: begin
        nextState = IDLE;
        nextGrant = '0;
      end
    endcase
  end

  assign grant = grantQ;
  assign owner = ownerQ;
  assign busy  = |grantQ;

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter: independent round-robin channels for the shared Data and
// Instruction buses.
module bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int N_CORES = DEFAULT_N_CORES,
  parameter int OWNER_W = $clog2(N_CORES)
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  rr_bus_channel #(.N_CORES(N_CORES), .OWNER_W(OWNER_W)) dChan (
    .clock (clock),
    .reset (reset),
    .rq    (bus.D_Bus_RQ),
    .grant (bus.D_Bus_GRANT),
    .owner (bus.D_Bus_Owner),
    .busy  (bus.D_Bus_Busy)
  );

  rr_bus_channel #(.N_CORES(N_CORES), .OWNER_W(OWNER_W)) iChan (
    .clock (clock),
    .reset (reset),
    .rq    (bus.I_Bus_RQ),
    .grant (bus.I_Bus_GRANT),
    .owner (bus.I_Bus_Owner),
    .busy  (bus.I_Bus_Busy)
  );

endmodule
